// File: rtl/gamepad_dev.sv
// gamepad_dev: device-side emulation of NES/SNES-style shift-register pads.
// Watches the host latch/clock/select pins, snapshots btn_value and streams it out active-low.

module gamepad_dev #(
    parameter int   SEL_WIDTH  = 1,
    parameter int   DATA_WIDTH = 2,
    parameter int   REG_WIDTH  = 12,
    parameter logic FILL       = 1'b1,
    parameter int   TIMEOUT    = 4096,
    localparam int  SL = (SEL_WIDTH > 1) ? SEL_WIDTH - 1 : 0,
    localparam int  DL = DATA_WIDTH - 1,
    localparam int  VL = ((REG_WIDTH * DATA_WIDTH) << SEL_WIDTH) - 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [SL:0] gp_sel,
    input  logic        gp_latch,
    input  logic        gp_clk,
    output logic [DL:0] gp_data,
    input  logic [VL:0] btn_value,
    output logic        busy,
    output logic        evt_latch,
    output logic        evt_done,
    output logic        evt_timeout
);
    localparam int CW = $clog2(REG_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] BIT_LAST = CW'(REG_WIDTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    logic [1:0]  latch_sync, clk_sync;
    logic        latch_d, clk_d;
    logic [SL:0] sel_meta, sel_s;
    logic        latch_s, clk_s, latch_fall, clk_rise;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latch_sync <= '0;
            clk_sync   <= '0;
            latch_d    <= 1'b0;
            clk_d      <= 1'b0;
            sel_meta   <= '0;
            sel_s      <= '0;
        end else begin
            latch_sync <= {latch_sync[0], gp_latch};
            clk_sync   <= {clk_sync[0], gp_clk};
            latch_d    <= latch_sync[1];
            clk_d      <= clk_sync[1];
            sel_meta   <= gp_sel;
            sel_s      <= sel_meta;
        end
    end

    assign latch_s    = latch_sync[1];
    assign clk_s      = clk_sync[1];
    assign latch_fall = latch_d & ~latch_s;
    assign clk_rise   = clk_s & ~clk_d;

    // Pad images of the group addressed by the synchronized select.
    int                         sel_idx;
    logic [DL:0][REG_WIDTH-1:0] sr_load;

    assign sel_idx = (SEL_WIDTH == 0) ? 0 : int'(sel_s);

    always_comb begin
        sr_load = '0;
        for (int d = 0; d < DATA_WIDTH; d++) begin
            sr_load[d] = btn_value[(sel_idx * DATA_WIDTH + d) * REG_WIDTH +: REG_WIDTH];
        end
    end

    state_t                     state, state_nx;
    logic [DL:0][REG_WIDTH-1:0] sr, sr_nx;
    logic [CW-1:0]              bit_cnt, bit_cnt_nx, bit_inc;
    logic [TW-1:0]              tmo_cnt, tmo_cnt_nx;
    logic [DL:0]                data_nx;
    logic                       evt_latch_nx, evt_done_nx, evt_timeout_nx;

    assign bit_inc = bit_cnt + CW'(1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        sr_nx          = sr;
        bit_cnt_nx     = bit_cnt;
        tmo_cnt_nx     = tmo_cnt;
        data_nx        = '1;
        evt_latch_nx   = 1'b0;
        evt_done_nx    = 1'b0;
        evt_timeout_nx = 1'b0;

        unique case (state)
            IDLE: begin
                tmo_cnt_nx = '0;
                if (latch_s) state_nx = LOAD;
            end
            LOAD: begin
                tmo_cnt_nx = '0;
                for (int d = 0; d < DATA_WIDTH; d++) data_nx[d] = ~sr_load[d][0];
                if (latch_fall) begin
                    // Keep the image loaded last cycle as the snapshot.
                    state_nx     = SHIFT;
                    evt_latch_nx = 1'b1;
                    bit_cnt_nx   = '0;
                end else begin
                    sr_nx = sr_load;
                end
            end
            SHIFT: begin
                for (int d = 0; d < DATA_WIDTH; d++) data_nx[d] = ~sr[d][0];
                if (latch_s) begin
                    state_nx   = LOAD;
                    tmo_cnt_nx = '0;
                end else if (clk_rise) begin
                    for (int d = 0; d < DATA_WIDTH; d++) sr_nx[d] = {~FILL, sr[d][REG_WIDTH-1:1]};
                    bit_cnt_nx = bit_inc;
                    tmo_cnt_nx = '0;
                    if (bit_inc == BIT_LAST) begin
                        state_nx    = DONE;
                        evt_done_nx = 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx       = IDLE;
                    evt_timeout_nx = 1'b1;
                end else begin
                    tmo_cnt_nx = tmo_cnt + TW'(1);
                end
            end
            DONE: begin
                data_nx = {DATA_WIDTH{FILL}};
                if (latch_s) begin
                    state_nx   = LOAD;
                    tmo_cnt_nx = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the shift registers are reset as well, so a reset mid-scan never leaks an old snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            gp_data     <= '1;
            evt_latch   <= 1'b0;
            evt_done    <= 1'b0;
            evt_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            sr          <= sr_nx;
            bit_cnt     <= bit_cnt_nx;
            tmo_cnt     <= tmo_cnt_nx;
            gp_data     <= data_nx;
            evt_latch   <= evt_latch_nx;
            evt_done    <= evt_done_nx;
            evt_timeout <= evt_timeout_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule
